sd_clk_ctrl: RTL

- Controls the SD card clock (SD_CLK) generated from the system clock `clk`.
- Sequences the power-up init phase of at least 74 card clocks, then normal running.
- Supports a stop request and glitch-free divisor changes.
- Sits between the host register block and the CMD/DAT engines. Those engines use its sd_rise/sd_fall strobes as clock enables; they do not clock from sd_clk.

---
 rtl/sd_clk_pkg.sv | 17 +
 rtl/sd_clk_div.sv | 45 ++++
 rtl/sd_clk_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sd_clk_pkg.sv
// Shared types and default constants for the SD card clock controller.
package sd_clk_pkg;

    localparam int unsigned DIV_W       = 16;
    localparam int unsigned DEFAULT_DIV = 124;
    localparam int unsigned INIT_CLKS   = 80;

    typedef logic [DIV_W-1:0] div_t;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        STOPPED
    } state_t;

endpackage

// File: rtl/sd_clk_div.sv
// Phase counter and toggle register for sd_clk, with registered rise/fall strobes.
module sd_clk_div #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             sd_clk,
    output logic             sd_rise,
    output logic             sd_fall
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            sd_clk  <= 1'b0;
            sd_rise <= 1'b0;
            sd_fall <= 1'b0;
        end else if (!run) begin
            cnt     <= '0;
            sd_clk  <= 1'b0;
            sd_rise <= 1'b0;
            sd_fall <= 1'b0;
        end else if (clear) begin
            // Divisor swap: restart the low phase without toggling.
            cnt     <= '0;
            sd_rise <= 1'b0;
            sd_fall <= 1'b0;
        end else if (cnt == div) begin
            cnt     <= '0;
            sd_clk  <= ~sd_clk;
            sd_rise <= ~sd_clk;
            sd_fall <= sd_clk;
        end else begin
            cnt     <= cnt + 1'b1;
            sd_rise <= 1'b0;
            sd_fall <= 1'b0;
        end
    end

endmodule

// File: rtl/sd_clk_ctrl.sv
// SD card clock controller: init sequencing, stop/park and glitch-free divisor change.
// Optional macro SD_CLK_INIT_BYPASS_EN adds init_bypass to skip the init phase.
module sd_clk_ctrl #(
    parameter int unsigned DIV_W       = sd_clk_pkg::DIV_W,
    parameter int unsigned DEFAULT_DIV = sd_clk_pkg::DEFAULT_DIV,
    parameter int unsigned INIT_CLKS   = sd_clk_pkg::INIT_CLKS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    input  logic             init_start,
    input  logic             clk_stop_req,
`ifdef SD_CLK_INIT_BYPASS_EN
    input  logic             init_bypass,
`endif
    output logic             sd_clk,
    output logic             sd_rise,
    output logic             sd_fall,
    output logic             init_done,
    output logic             div_busy,
    output logic             clk_running
);

    import sd_clk_pkg::*;

    localparam int unsigned     EDGE_W    = $clog2(INIT_CLKS + 1);
    localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DEFAULT_DIV);
    localparam logic [EDGE_W-1:0] EDGE_DONE = EDGE_W'(INIT_CLKS);

    state_t            state;
    logic [DIV_W-1:0]  div_cur;
    logic [DIV_W-1:0]  div_pend;
    logic [EDGE_W-1:0] edge_cnt;
    logic              active;
    logic              stop_now;
    logic              apply;
    logic              run;
    logic              bypass;

    always_comb begin
        active   = (state == INIT) || (state == RUN);
        stop_now = (state == RUN) && sd_fall && clk_stop_req;
        apply    = active && div_busy && sd_fall;
        run      = active && !stop_now;
`ifdef SD_CLK_INIT_BYPASS_EN
        bypass   = init_bypass;
`else
        bypass   = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            div_cur     <= DIV_RST;
            div_pend    <= '0;
            edge_cnt    <= '0;
            init_done   <= 1'b0;
            div_busy    <= 1'b0;
            clk_running <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_load)
                        div_cur <= div_in;
                    if (init_start) begin
                        clk_running <= 1'b1;
                        if (bypass) begin
                            state     <= RUN;
                            init_done <= 1'b1;
                        end else begin
                            state <= INIT;
                        end
                    end
                end
                INIT, RUN: begin
                    if (stop_now) begin
                        // Stop parks the clock, so any divisor change lands immediately.
                        state       <= STOPPED;
                        clk_running <= 1'b0;
                        div_busy    <= 1'b0;
                        if (div_load)
                            div_cur <= div_in;
                        else if (div_busy)
                            div_cur <= div_pend;
                    end else begin
                        if (apply) begin
                            div_cur  <= div_pend;
                            div_busy <= 1'b0;
                        end
                        if (div_load) begin
                            div_pend <= div_in;
                            div_busy <= 1'b1;
                        end
                        if (state == INIT && sd_rise && edge_cnt != EDGE_DONE)
                            edge_cnt <= edge_cnt + 1'b1;
                        if (state == INIT && sd_fall && edge_cnt == EDGE_DONE) begin
                            state     <= RUN;
                            init_done <= 1'b1;
                        end
                    end
                end
                STOPPED: begin
                    if (div_load)
                        div_cur <= div_in;
                    if (!clk_stop_req) begin
                        state       <= RUN;
                        clk_running <= 1'b1;
                    end
                end
            endcase
        end
    end

    sd_clk_div #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .clear  (apply),
        .div    (div_cur),
        .sd_clk (sd_clk),
        .sd_rise(sd_rise),
        .sd_fall(sd_fall)
    );

endmodule
